// File: rtl/stream_demux_pkg.sv
// Shared types for the stream demultiplexer: holding-stage state encoding.
package stream_demux_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/stream_demux_decoder.sv
// Index-to-one-hot decoder; all outputs low when en is low.
module stream_demux_decoder #(
  parameter  int NUM_WIRE = 6,
  localparam int SEL_W    = $clog2(NUM_WIRE)
) (
  input  logic                en,
  input  logic [SEL_W-1:0]    idx,
  output logic [NUM_WIRE-1:0] dec
);
  for (genvar k = 0; k < NUM_WIRE; k++) begin : g_wire
    assign dec[k] = en && (idx == SEL_W'(k));
  end
endmodule

// File: rtl/stream_demux.sv
// One-stage valid/ready demultiplexer routing each beat to the channel named by s_i.
// Define STREAM_DEMUX_ERR_EN to enable the sticky out-of-range-select flag err_o.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int NUM_ELEM   = 6,
  parameter  int ELEM_WIDTH = 8,
  localparam int SEL_W      = $clog2(NUM_ELEM)
) (
  input  logic                                 clk_i,
  input  logic                                 arst_i,
  input  logic [SEL_W-1:0]                     s_i,
  input  logic [ELEM_WIDTH-1:0]                i_i,
  input  logic                                 i_valid_i,
  output logic                                 i_ready_o,
  output logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  o_o,
  output logic [NUM_ELEM-1:0]                  o_valid_o,
  input  logic [NUM_ELEM-1:0]                  o_ready_i,
  output logic                                 err_o,
  input  logic                                 clear_i
);
  state_e                state_q, state_d;
  logic [ELEM_WIDTH-1:0] data_q;
  logic [SEL_W-1:0]      idx_q;
  logic                  full, in_range, accept, load, out_hs;

  assign full     = (state_q == FULL);
  assign in_range = {1'b0, s_i} < (SEL_W+1)'(NUM_ELEM);

  stream_demux_decoder #(.NUM_WIRE(NUM_ELEM)) u_dec (
    .en  (full),
    .idx (idx_q),
    .dec (o_valid_o)
  );

  // Only the selected channel's ready can complete the handshake.
  assign out_hs    = |(o_valid_o & o_ready_i);
  assign i_ready_o = !full || out_hs;
  assign accept    = i_valid_i && i_ready_o;
  assign load      = accept && in_range;

  always_comb begin
    state_d = state_q;
    if (load)        state_d = FULL;
    else if (out_hs) state_d = EMPTY;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      data_q <= i_i;
      idx_q  <= s_i;
    end
  end

  for (genvar k = 0; k < NUM_ELEM; k++) begin : g_out
    assign o_o[k] = o_valid_o[k] ? data_q : '0;
  end

`ifdef STREAM_DEMUX_ERR_EN
  logic err_q;
  // Set wins over clear so a discard in the clearing cycle is not lost.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)                     err_q <= 1'b0;
    else if (accept && !in_range)   err_q <= 1'b1;
    else if (clear_i)               err_q <= 1'b0;
  end
  assign err_o = err_q;
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign err_o        = 1'b0;
`endif
endmodule

// File: tb/tb_stream_demux.sv
// Randomized bench for stream_demux against a queue-based reference model.
module tb_stream_demux;
  localparam int NE = 6;
  localparam int W  = 8;
  localparam int SW = 3;
`ifdef STREAM_DEMUX_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               arst_i = 1'b1;
  logic [SW-1:0]      s_i = '0;
  logic [W-1:0]       i_i = '0;
  logic               i_valid_i = 1'b0;
  logic               i_ready_o;
  logic [NE-1:0][W-1:0] o_o;
  logic [NE-1:0]      o_valid_o;
  logic [NE-1:0]      o_ready_i = '0;
  logic               err_o;
  logic               clear_i = 1'b0;
  logic [NE*W-1:0]    o_flat;

  assign o_flat = o_o;

  stream_demux #(.NUM_ELEM(NE), .ELEM_WIDTH(W)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .s_i(s_i), .i_i(i_i),
    .i_valid_i(i_valid_i), .i_ready_o(i_ready_o), .o_o(o_o),
    .o_valid_o(o_valid_o), .o_ready_i(o_ready_i),
    .err_o(err_o), .clear_i(clear_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int ch; logic [W-1:0] d; } beat_t;
  beat_t sb[$];          // accepted, not yet delivered beats
  logic  err_exp = 1'b0;
  int    n_chk = 0, n_fail = 0, n_acc = 0, n_del = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs before the edge, advance the model.
  task automatic cyc(input logic v, input int sel, input logic [W-1:0] d,
                     input logic [NE-1:0] rdy, input logic clr);
    logic [NE-1:0]   ev;
    logic [NE*W-1:0] eo;
    logic            er, hs, acc, inr;
    beat_t           b;
    i_valid_i = v; s_i = SW'(sel); i_i = d; o_ready_i = rdy; clear_i = clr;
    @(negedge clk_i);
    ev = '0; eo = '0;
    if (sb.size() > 0) begin
      ev[sb[0].ch] = 1'b1;
      eo[sb[0].ch*W +: W] = sb[0].d;
    end
    hs  = (ev & rdy) != '0;
    er  = (sb.size() == 0) || hs;
    acc = v && er;
    inr = sel < NE;
    chk("i_ready", 64'(i_ready_o), 64'(er));
    chk("o_valid", 64'(o_valid_o), 64'(ev));
    chk("o_o", 64'(o_flat), 64'(eo));
    chk("err", 64'(err_o), 64'(err_exp));
    chk("onehot", 64'($countones(o_valid_o) <= 1), 64'(1));
    if ((o_valid_o & rdy) != '0) n_del++;
    @(posedge clk_i);
    if (hs) void'(sb.pop_front());
    if (acc && inr) begin
      b.ch = sel; b.d = d;
      sb.push_back(b);
      n_acc++;
    end
    if (ERR_EN && acc && !inr) err_exp = 1'b1;
    else if (clr)              err_exp = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, '0, '1, 1'b0);
  endtask

  initial begin
    logic [NE-1:0] rdy;
    int            guard;
    #3;
    chk("rst_valid", 64'(o_valid_o), 64'(0));
    chk("rst_o", 64'(o_flat), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    repeat (2) @(posedge clk_i);
    #1 arst_i = 1'b0;
    chk("rst_ready", 64'(i_ready_o), 64'(1));

    // single beat to channel 3
    cyc(1'b1, 3, 8'hA5, '1, 1'b0);
    chk("single_valid", 64'(o_valid_o), 64'(6'b001000));
    chk("single_data", 64'(o_flat), 64'(48'h0000_A500_0000));
    idle(1);
    chk("single_empty", 64'(o_valid_o), 64'(0));

    // back-to-back, no bubbles
    cyc(1'b1, 0, 8'h10, '1, 1'b0);
    cyc(1'b1, 1, 8'h21, '1, 1'b0);
    cyc(1'b1, 2, 8'h32, '1, 1'b0);
    cyc(1'b1, 0, 8'h40, '1, 1'b0);
    idle(2);

    // stall on channel 2; ready on channel 4 must not matter
    cyc(1'b1, 2, 8'h3C, '1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, $urandom_range(0, NE-1), 8'($urandom), 6'b010000, 1'b0);
      chk("stall_data", 64'(o_flat), 64'(48'h0000_003C_0000));
    end
    cyc(1'b0, 0, '0, 6'b000100, 1'b0);
    chk("stall_done", 64'(o_valid_o), 64'(0));

    // out-of-range select, sticky flag and set-vs-clear priority
    cyc(1'b1, 7, 8'h11, '1, 1'b0);
    chk("oor_valid", 64'(o_valid_o), 64'(0));
    chk("oor_err", 64'(err_o), 64'(ERR_EN));
    idle(3);
    cyc(1'b1, 6, 8'h22, '1, 1'b1);
    chk("oor_setclr", 64'(err_o), 64'(ERR_EN));
    cyc(1'b0, 0, '0, '1, 1'b1);
    chk("oor_clear", 64'(err_o), 64'(0));

    // reset while a stalled beat is held
    cyc(1'b1, 2, 8'h77, '0, 1'b0);
    cyc(1'b0, 0, '0, '0, 1'b0);
    arst_i = 1'b1;
    #1;
    chk("arst_valid", 64'(o_valid_o), 64'(0));
    chk("arst_o", 64'(o_flat), 64'(0));
    sb.delete();
    err_exp = 1'b0;
    @(posedge clk_i);
    #1 arst_i = 1'b0;
    idle(2);

    // random traffic
    n_acc = 0; n_del = 0; guard = 0;
    while (n_acc < 10000 && guard < 60000) begin
      for (int k = 0; k < NE; k++) rdy[k] = ($urandom_range(0, 9) < 7);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), 8'($urandom), rdy,
          $urandom_range(0, 19) == 0);
      guard++;
    end
    chk("rand_beats", 64'(n_acc), 64'(10000));
    idle(3);
    chk("drain_sb", 64'(sb.size()), 64'(0));
    chk("delivered", 64'(n_del), 64'(n_acc));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter NUM_ELEM, default 6, SHALL set the number of output channels (>= 2).
REQ-002 Parameter ELEM_WIDTH, default 8, SHALL set the data width per beat (>= 1).
REQ-003 Localparam SEL_W SHALL equal $clog2(NUM_ELEM).
REQ-004 Port clk_i  in  1 SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port arst_i  in  1 SHALL be the reset: asynchronous assert, active-high, released synchronously to clk_i externally.
REQ-006 Port s_i  in  SEL_W SHALL be the destination channel index for the input beat.
REQ-007 Port i_i  in  ELEM_WIDTH SHALL be the input data.
REQ-008 Port i_valid_i  in  1 SHALL mark i_i/s_i as a valid beat.
REQ-009 Port i_ready_o  out  1 SHALL indicate the block accepts the beat this cycle.
REQ-010 Port o_o  out  NUM_ELEM x ELEM_WIDTH SHALL be the per-channel output data.
REQ-011 Port o_valid_o  out  NUM_ELEM SHALL be the per-channel valid, at most one bit high (one-hot or zero).
REQ-012 Port o_ready_i  in  NUM_ELEM SHALL be the per-channel ready from consumers.
REQ-013 Port err_o  out  1 SHALL be the sticky out-of-range-select flag; port clear_i  in  1 SHALL clear it.

Function
REQ-014 Input handshake SHALL complete when i_valid_i && i_ready_o; output handshake on channel k when o_valid_o[k] && o_ready_i[k].
REQ-015 The block SHALL hold one registered stage: state EMPTY or FULL, plus data register and SEL_W-bit index register.
REQ-016 EMPTY -> FULL on an accepted in-range beat; FULL -> EMPTY on output handshake with no new accept; FULL -> FULL on simultaneous output handshake and accept (pass-through, no bubble).
REQ-017 i_ready_o SHALL be high when EMPTY, or when FULL and o_ready_i[index] is high (combinational path from o_ready_i only; never from i_valid_i).
REQ-018 Latency SHALL be one cycle: beat accepted in cycle N appears on o_valid_o in cycle N+1; sustained throughput one beat per cycle when the target is ready.
REQ-019 o_valid_o[k] SHALL be high iff FULL and index == k; o_o[k] SHALL equal the data register when o_valid_o[k], else all zeros.
REQ-020 Once o_valid_o[k] rises, data and index SHALL remain stable until the handshake on k completes (no retraction).
REQ-021 Out-of-range beat (s_i >= NUM_ELEM, only possible when NUM_ELEM is not a power of 2) SHALL be accepted under the same i_ready_o rule, discarded, and not enter FULL; if it coincides with an output handshake the state SHALL go EMPTY.
REQ-022 o_ready_i on unselected channels SHALL have no effect.

Reset
REQ-023 While arst_i is high: state EMPTY, o_valid_o = 0, o_o = 0, i_ready_o = 1 as soon as reset deasserts, err_o = 0, data/index registers = 0.
REQ-024 Reset asserted mid-transfer SHALL drop the held beat without any output handshake.

Configuration
REQ-025 With STREAM_DEMUX_ERR_EN defined: an accepted out-of-range beat SHALL set err_o on the next edge; err_o stays high until clear_i is sampled high; a simultaneous set and clear SHALL leave err_o set.
REQ-026 Without STREAM_DEMUX_ERR_EN: err_o SHALL be constant 0, clear_i ignored, out-of-range beats still discarded per REQ-021.

Structure
REQ-027 A shared package stream_demux_pkg SHALL hold the state enum (EMPTY, FULL).
REQ-028 Output valid fan-out SHALL use the existing decoder sub-module (NUM_WIRE = NUM_ELEM, enable = FULL) driven by the index register.

Verification
REQ-029 Reset then single beat s_i=3, i_i=0xA5, o_ready_i all 1 -> cycle N+1 o_valid_o=6'b001000, o_o[3]=0xA5, others 0; EMPTY after.
REQ-030 Back-to-back beats to channels 0,1,2,0 with all ready -> i_ready_o stays 1, one output per cycle in order, no bubbles.
REQ-031 Beat to channel 2 with o_ready_i[2]=0 for 5 cycles, o_ready_i[4]=1 -> i_ready_o=0, o_o[2] stable for 5 cycles; handshake on 6th; o_ready_i[4] ignored.
REQ-032 NUM_ELEM=6, beat s_i=7 -> no o_valid_o; with STREAM_DEMUX_ERR_EN err_o=1 next cycle until clear_i pulse; without macro err_o=0.
REQ-033 arst_i asserted while FULL with channel stalled -> o_valid_o=0 and o_o=0 immediately (asynchronous), no handshake recorded.
REQ-034 Random valid/ready/select, 10k beats -> scoreboard: every in-range beat delivered exactly once to its channel, in order, o_valid_o never multi-hot.
